shift_sequencer: RTL

Multi-cycle shift unit controller that processes one shift request over several cycles, reusing a single 1-stage shifter instead of the full 5-stage combinational barrel shifter. It accepts a request over a valid/ready handshake and applies the power-of-two stages from largest to smallest, one per cycle, selected by the shift-amount bits. It returns the result over a second valid/ready handshake. The processor's execute stage uses it for SLL/SRL/SRA/ROR when area matters more than latency.

---
 rtl/shift_sequencer_pkg.sv | 19 +
 rtl/shift_sequencer_shift_stage.sv | 32 +++
 rtl/shift_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the multi-cycle shift sequencer.
package shift_sequencer_pkg;

   // Shift operation encoding as presented on the op port
   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRL = 2'b01,
      SHIFT_SRA = 2'b10,
      SHIFT_ROR = 2'b11
   } shift_op_t;

   // Sequencer control states
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } seq_state_t;

endpackage

// File: rtl/shift_sequencer_shift_stage.sv
// Single power-of-two shift stage: shifts acc by 2^stage according to op.
module shift_stage
   import shift_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH),
   parameter int unsigned STAGE_W = $clog2(SHAMT_W)
) (
   input  logic [WIDTH-1:0]   acc,
   input  shift_op_t          op,
   input  logic [STAGE_W-1:0] stage,
   output logic [WIDTH-1:0]   shifted
);

   logic [SHAMT_W-1:0]   amt;
   logic [2*WIDTH-1:0]   rot;

   // Select the shift flavour for a distance of 2^stage
   always_comb begin
      amt     = SHAMT_W'(1) << stage;
      rot     = {acc, acc} >> amt;
      shifted = acc;
      unique case (op)
         SHIFT_SLL: shifted = acc << amt;
         SHIFT_SRL: shifted = acc >> amt;
         SHIFT_SRA: shifted = $signed(acc) >>> amt;
         SHIFT_ROR: shifted = rot[WIDTH-1:0];
         default:   shifted = acc;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: one request is applied over SHAMT_W cycles
// through a single shift stage, largest stage first.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   data_operand,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               busy
);

   localparam int unsigned            STAGE_W    = $clog2(SHAMT_W);
   localparam logic [STAGE_W-1:0]     LAST_STAGE = STAGE_W'(SHAMT_W - 1);

   seq_state_t          state;
   logic [WIDTH-1:0]    acc;
   shift_op_t           op_q;
   logic [SHAMT_W-1:0]  shamt_q;
   logic [STAGE_W-1:0]  stage;
   logic [WIDTH-1:0]    shifted;

   shift_stage #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W),
      .STAGE_W (STAGE_W)
   ) u_stage (
      .acc     (acc),
      .op      (op_q),
      .stage   (stage),
      .shifted (shifted)
   );

   assign result = acc;

   // Control FSM with registered handshake and busy outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         op_q      <= SHIFT_SLL;
         shamt_q   <= '0;
         stage     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               // in_ready is always high in IDLE, so in_valid alone is the accept
               if (in_valid) begin
                  acc      <= data_operand;
                  op_q     <= shift_op_t'(op);
                  shamt_q  <= shamt;
                  stage    <= LAST_STAGE;
                  state    <= SHIFT;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            SHIFT: begin
               if (shamt_q[stage]) acc <= shifted;
               if (stage == '0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  stage <= stage - STAGE_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
